// File: rtl/multicycle_control_fsm.sv
// Main control sequencer for the multicycle RV32 subset core
// (add, and, sll, ori, lb, sb, beq, bne).
// Each instruction steps through the FETCH, DECODE, EXECUTE, MEMORY and
// WRITEBACK phases. How many phases it visits, and for how long, depends
// on its opcode.
//
// Optional build macro: CTRL_PERF_COUNT_EN adds the 'retired' counter of
// legal instructions completed.
//
// Ports:
//   clock, reset      clock and synchronous active-high reset
//   run               start/continue execution; sampled at instruction boundaries
//   opcode, funct3    fields from the instruction register
//   zero              ALU zero flag, used by branches in EXECUTE
//   aluOp, aluSrcB    ALU control to alu_control and the operand-B mux
//   irWrite, pcWrite  IR load and PC+4 update (final FETCH cycle)
//   pcBranch          PC <= branch target
//   memRead, memWrite data memory strobes
//   regWrite, memToReg register file write and writeback source
//   phase             0 IDLE, 1 FETCH, 2 DECODE, 3 EXECUTE, 4 MEMORY, 5 WRITEBACK
//   illegal           one-cycle pulse in DECODE for an unsupported opcode
//   retired           (CTRL_PERF_COUNT_EN only) retired-instruction count
module multicycle_control_fsm #(
  parameter int unsigned FETCH_WAIT = 1,
  parameter int unsigned MEM_WAIT   = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        zero,
  output logic [1:0]  aluOp,
  output logic        aluSrcB,
  output logic        irWrite,
  output logic        pcWrite,
  output logic        pcBranch,
  output logic        memRead,
  output logic        memWrite,
  output logic        regWrite,
  output logic        memToReg,
  output logic [2:0]  phase,
  output logic        illegal
`ifdef CTRL_PERF_COUNT_EN
  ,
  output logic [31:0] retired
`endif
);

  localparam int unsigned CNT_W = 3;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ORI    = 7'b0010011;
  localparam logic [6:0] OP_LB     = 7'b0000011;
  localparam logic [6:0] OP_SB     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [6:0]         op_q, op_d;
  logic [2:0]         f3_q, f3_d;

  logic   fetch_last, mem_last, dec_legal;
  logic   is_rtype, is_ori, is_lb, is_sb, is_branch;
  state_e boundary_c;

  assign fetch_last = (cnt_q == CNT_W'(FETCH_WAIT - 1));
  assign mem_last   = (cnt_q == CNT_W'(MEM_WAIT - 1));

  // Class of the latched instruction (valid from EXECUTE onwards)
  assign is_rtype  = (op_q == OP_RTYPE);
  assign is_ori    = (op_q == OP_ORI);
  assign is_lb     = (op_q == OP_LB);
  assign is_sb     = (op_q == OP_SB);
  assign is_branch = (op_q == OP_BRANCH);

  // Legality is judged on the live IR contents during DECODE
  assign dec_legal = (opcode == OP_RTYPE) || (opcode == OP_ORI) || (opcode == OP_LB) ||
                     (opcode == OP_SB) || (opcode == OP_BRANCH);

  // Where an instruction goes once it is finished
  assign boundary_c = run ? S_FETCH : S_IDLE;

  // State, wait counter and latched instruction fields
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      f3_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      f3_q    <= f3_d;
    end
  end

  // Next state and Moore outputs; the counter defaults to zero so every
  // state entry starts from a cleared count
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    op_d     = op_q;
    f3_d     = f3_q;
    aluOp    = 2'b00;
    aluSrcB  = 1'b0;
    irWrite  = 1'b0;
    pcWrite  = 1'b0;
    pcBranch = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    regWrite = 1'b0;
    memToReg = 1'b0;
    illegal  = 1'b0;
    phase    = state_q;

    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (fetch_last) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          state_d = S_DECODE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        op_d = opcode;
        f3_d = funct3;
        if (dec_legal) begin
          state_d = S_EXECUTE;
        end else begin
          illegal = 1'b1;
          state_d = boundary_c;
        end
      end
      S_EXECUTE: begin
        if (is_rtype) begin
          aluOp   = 2'b10;
          state_d = S_WRITEBACK;
        end else if (is_ori) begin
          aluOp   = 2'b10;
          aluSrcB = 1'b1;
          state_d = S_WRITEBACK;
        end else if (is_lb || is_sb) begin
          aluSrcB = 1'b1;
          state_d = S_MEMORY;
        end else if (is_branch) begin
          aluOp = 2'b01;
          if (f3_q == 3'b000)      pcBranch = zero;
          else if (f3_q == 3'b001) pcBranch = ~zero;
          state_d = boundary_c;
        end else begin
          state_d = boundary_c;
        end
      end
      S_MEMORY: begin
        // Address stays on the ALU (aluOp 00, immediate) for the whole access
        aluSrcB = 1'b1;
        memRead = is_lb;
        if (mem_last) begin
          memWrite = is_sb;
          state_d  = is_lb ? S_WRITEBACK : boundary_c;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WRITEBACK: begin
        regWrite = 1'b1;
        memToReg = is_lb;
        aluOp    = (is_rtype || is_ori) ? 2'b10 : 2'b00;
        aluSrcB  = is_ori || is_lb;
        state_d  = boundary_c;
      end
      default: state_d = S_IDLE;
    endcase

    // No architectural side effect may escape in a reset cycle
    if (reset) begin
      memWrite = 1'b0;
      regWrite = 1'b0;
    end
  end

`ifdef CTRL_PERF_COUNT_EN
  logic [31:0] retired_q, retired_d;
  logic        retire_c;

  // A legal instruction finishes on its last cycle
  assign retire_c = (state_q == S_WRITEBACK) ||
                    ((state_q == S_EXECUTE) && is_branch) ||
                    ((state_q == S_MEMORY) && is_sb && mem_last);

  always_comb retired_d = retired_q + 32'(retire_c);

  always_ff @(posedge clock) begin
    if (reset) retired_q <= '0;
    else       retired_q <= retired_d;
  end

  assign retired = retired_q;
`endif

endmodule
